// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
//   Registered, handshaked ALU-control decoder for the ID/EX boundary.
//   Turns ALUOp/funct into an ALU/shifter operation code, a result select
//   (ALU, shifter, HI, LO) and a HI/LO write enable. A `mult` instruction
//   stalls the upstream side for a counted MUL_LAT-cycle multiplier sequence
//   and is then delivered downstream as a single HI/LO write.
//
//   Optional build macro:
//     ALU_CTRL_SRA_EN  - decode sra (000011) and srav (000111) as shifter
//                        ops; without it both codes decode as illegal.
//
//   Reset: rst_i is synchronous and active-low.
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
    parameter int ALUOP_W = 3,
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    // upstream (main decoder)
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [5:0]         funct_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    // downstream (EX stage)
    output logic               valid_o,
    input  logic               ready_i,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic [1:0]         FURslt_o,
    output logic               hilo_we_o,
    output logic               mul_start_o,
    output logic               illegal_o
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Result-select encodings
    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_SHF = 2'd1;
    localparam logic [1:0] FU_HI  = 2'd2;
    localparam logic [1:0] FU_LO  = 2'd3;

    // Operation codes (4-bit, zero-extended to CTRL_W on output)
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLLV = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SRLV = 4'b1101;
    localparam logic [3:0] OP_MULT = 4'b1110;
    localparam logic [3:0] OP_ILL  = 4'b1111;
`ifdef ALU_CTRL_SRA_EN
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SRAV = 4'b1010;
`endif

    // The multiplier sequence counts MUL_LAT-1 down to 0, then one more
    // cycle to land in DONE, giving accept->valid_o of MUL_LAT+1 cycles.
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

    typedef struct packed {
        logic [3:0] code;
        logic [1:0] fu;
        logic       illegal;
        logic       is_mult;
    } dec_t;

    // -----------------------------------------------------------------------
    // Decoder helpers
    // -----------------------------------------------------------------------
    function automatic dec_t legal(input logic [3:0] code, input logic [1:0] fu);
        dec_t d;
        d.code    = code;
        d.fu      = fu;
        d.illegal = 1'b0;
        d.is_mult = 1'b0;
        return d;
    endfunction

    function automatic dec_t decode_funct(input logic [5:0] f);
        dec_t d;
        d = '{code: OP_ILL, fu: FU_ALU, illegal: 1'b1, is_mult: 1'b0};
        case (f)
            6'b100000: d = legal(OP_ADD,  FU_ALU);
            6'b100010: d = legal(OP_SUB,  FU_ALU);
            6'b100100: d = legal(OP_AND,  FU_ALU);
            6'b100101: d = legal(OP_OR,   FU_ALU);
            6'b100111: d = legal(OP_NOR,  FU_ALU);
            6'b101010: d = legal(OP_SLT,  FU_ALU);
            6'b000000: d = legal(OP_SLL,  FU_SHF);
            6'b000010: d = legal(OP_SRL,  FU_SHF);
            6'b000100: d = legal(OP_SLLV, FU_SHF);
            6'b000110: d = legal(OP_SRLV, FU_SHF);
`ifdef ALU_CTRL_SRA_EN
            6'b000011: d = legal(OP_SRA,  FU_SHF);
            6'b000111: d = legal(OP_SRAV, FU_SHF);
`endif
            6'b010000: d = legal(OP_ADD,  FU_HI);
            6'b010010: d = legal(OP_ADD,  FU_LO);
            6'b011000: begin
                d = legal(OP_MULT, FU_ALU);
                d.is_mult = 1'b1;
            end
            default:   ;
        endcase
        return d;
    endfunction

    function automatic dec_t decode(input logic [ALUOP_W-1:0] op, input logic [5:0] f);
        dec_t d;
        d = '{code: OP_ILL, fu: FU_ALU, illegal: 1'b1, is_mult: 1'b0};
        case (op)
            ALUOP_W'(3'b000): d = legal(OP_ADD, FU_ALU);   // lw/sw
            ALUOP_W'(3'b001): d = legal(OP_SUB, FU_ALU);   // bne
            ALUOP_W'(3'b010): d = decode_funct(f);         // R-type
            ALUOP_W'(3'b011): d = legal(OP_OR,  FU_ALU);   // ori
            ALUOP_W'(3'b100): d = legal(OP_ADD, FU_ALU);   // addi
            ALUOP_W'(3'b101): d = legal(OP_SLT, FU_ALU);   // slti
            ALUOP_W'(3'b110): d = legal(OP_SUB, FU_ALU);   // beq
            default:          ;                            // 111 and above
        endcase
        return d;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [3:0]          cnt_q,       cnt_d;
    logic                valid_q,     valid_d;
    logic [CTRL_W-1:0]   ctrl_q,      ctrl_d;
    logic [1:0]          fu_q,        fu_d;
    logic                hilo_we_q,   hilo_we_d;
    logic                mul_start_q, mul_start_d;
    logic                illegal_q,   illegal_d;

    dec_t                dec;
    logic                accept;

    // Decode the upstream fields every cycle; only used on accept.
    assign dec    = decode(ALUOp_i, funct_i);
    assign accept = valid_i && ready_o;

    // State register: every flop takes its next-state value or clears on reset.
    // NOTE: sequential state uses non-blocking (<=) so all flops sample the
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            // NOTE: every control flop is reset explicitly; there is no storage
            // array here whose reset would be costly, so nothing is left unreset.
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            fu_q        <= 2'd0;
            hilo_we_q   <= 1'b0;
            mul_start_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            fu_q        <= fu_d;
            hilo_we_q   <= hilo_we_d;
            mul_start_q <= mul_start_d;
            illegal_q   <= illegal_d;
        end
    end

    // Next-state logic: handshake, decode capture and the multiply sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case; any path that
        // skipped an assignment would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        fu_d        = fu_q;
        hilo_we_d   = hilo_we_q;
        mul_start_d = 1'b0;
        illegal_d   = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dec.is_mult) begin
                        // Nothing is in flight downstream (ready_o needed it
                        // drained), so the output slot goes empty while the
                        // multiplier runs.
                        state_d     = S_MUL;
                        cnt_d       = MUL_CNT_INIT;
                        mul_start_d = 1'b1;
                        valid_d     = 1'b0;
                        ctrl_d      = '0;
                        fu_d        = FU_ALU;
                        illegal_d   = 1'b0;
                        hilo_we_d   = 1'b0;
                    end else begin
                        valid_d     = 1'b1;
                        ctrl_d      = CTRL_W'(dec.code);
                        fu_d        = dec.fu;
                        illegal_d   = dec.illegal;
                        hilo_we_d   = 1'b0;
                    end
                end else if (ready_i) begin
                    // Downstream consumed the result and nothing replaces it.
                    valid_d = 1'b0;
                end
            end

            S_MUL: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_DONE;
                    valid_d   = 1'b1;
                    ctrl_d    = CTRL_W'(OP_MULT);
                    fu_d      = FU_ALU;
                    illegal_d = 1'b0;
                    hilo_we_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_DONE: begin
                // Hold the HI/LO write until the EX stage takes it.
                if (ready_i) begin
                    state_d   = S_IDLE;
                    valid_d   = 1'b0;
                    hilo_we_d = 1'b0;
                end
            end

            default: begin
                state_d   = S_IDLE;
                valid_d   = 1'b0;
                hilo_we_d = 1'b0;
            end
        endcase
    end

    // Output logic: upstream ready and the registered downstream fields.
    always_comb begin
        // Accept only when idle and the output slot is empty or draining now;
        // this gives back-to-back transfers with no bubble.
        ready_o     = (state_q == S_IDLE) && (!valid_q || ready_i);
        valid_o     = valid_q;
        ALUCtrl_o   = ctrl_q;
        FURslt_o    = fu_q;
        hilo_we_o   = hilo_we_q;
        mul_start_o = mul_start_q;
        illegal_o   = illegal_q;
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
//   Scoreboard bench for alu_ctrl_seq. Expected results are pushed when an
//   instruction is accepted and compared when the DUT presents valid_o.
//   Honors ALU_CTRL_SRA_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_ctrl_seq;

    localparam int ALUOP_W = 3;
    localparam int CTRL_W  = 4;
    localparam int MUL_LAT = 4;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               valid_i;
    logic               ready_o;
    logic [5:0]         funct_i;
    logic [ALUOP_W-1:0] ALUOp_i;
    logic               valid_o;
    logic               ready_i;
    logic [CTRL_W-1:0]  ALUCtrl_o;
    logic [1:0]         FURslt_o;
    logic               hilo_we_o;
    logic               mul_start_o;
    logic               illegal_o;

    alu_ctrl_seq #(
        .ALUOP_W (ALUOP_W),
        .CTRL_W  (CTRL_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .funct_i     (funct_i),
        .ALUOp_i     (ALUOp_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .ALUCtrl_o   (ALUCtrl_o),
        .FURslt_o    (FURslt_o),
        .hilo_we_o   (hilo_we_o),
        .mul_start_o (mul_start_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected downstream record: {ctrl, furslt, illegal, hilo_we}
    typedef struct packed {
        logic [3:0] ctrl;
        logic [1:0] fu;
        logic       ill;
        logic       hilo;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] c, input logic [1:0] fu);
        exp_t e;
        e.ctrl = c;
        e.fu   = fu;
        e.ill  = 1'b0;
        e.hilo = 1'b0;
        return e;
    endfunction

    // Reference decode, written from the instruction tables.
    function automatic exp_t model(input logic [2:0] op, input logic [5:0] f);
        exp_t e;
        e.ctrl = 4'b1111;
        e.fu   = 2'd0;
        e.ill  = 1'b1;
        e.hilo = 1'b0;
        case (op)
            3'b000, 3'b100: e = mk(4'b0010, 2'd0);
            3'b001, 3'b110: e = mk(4'b0110, 2'd0);
            3'b011:         e = mk(4'b0001, 2'd0);
            3'b101:         e = mk(4'b0111, 2'd0);
            3'b010: begin
                case (f)
                    6'b100000: e = mk(4'b0010, 2'd0);
                    6'b100010: e = mk(4'b0110, 2'd0);
                    6'b100100: e = mk(4'b0000, 2'd0);
                    6'b100101: e = mk(4'b0001, 2'd0);
                    6'b100111: e = mk(4'b1100, 2'd0);
                    6'b101010: e = mk(4'b0111, 2'd0);
                    6'b000000: e = mk(4'b0011, 2'd1);
                    6'b000010: e = mk(4'b0100, 2'd1);
                    6'b000100: e = mk(4'b1011, 2'd1);
                    6'b000110: e = mk(4'b1101, 2'd1);
`ifdef ALU_CTRL_SRA_EN
                    6'b000011: e = mk(4'b0101, 2'd1);
                    6'b000111: e = mk(4'b1010, 2'd1);
`endif
                    6'b010000: e = mk(4'b0010, 2'd2);
                    6'b010010: e = mk(4'b0010, 2'd3);
                    6'b011000: begin
                        e = mk(4'b1110, 2'd0);
                        e.hilo = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: sample between edges; compare the head while valid_o is up,
    // pop on handshake, push on accept.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1) begin
            if (valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(valid_o), 32'd0);
                end else begin
                    check("result", 32'({ALUCtrl_o, FURslt_o, illegal_o, hilo_we_o}), 32'(sb[0]));
                    if (ready_i) void'(sb.pop_front());
                end
            end
            if (valid_i && ready_o) sb.push_back(model(ALUOp_i, funct_i));
        end
    end

    // Present one instruction and wait for it to be accepted; n = cycles taken.
    task automatic send(input logic [2:0] op, input logic [5:0] f, output int n);
        bit acc;
        acc = 1'b0;
        n = 0;
        valid_i = 1'b1;
        ALUOp_i = op;
        funct_i = f;
        while (!acc && n < 50) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        valid_i = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk_i);
            #1;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101, F_NOR = 6'b100111, F_SLT = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000, F_MFHI = 6'b010000;

    initial begin
        logic [5:0] stream_f [6];
        logic [3:0] stream_c [6];
        logic [5:0] shift_f  [6];
        int n;

        stream_f = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT};
        stream_c = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
        shift_f  = '{6'b000000, 6'b000010, 6'b000100, 6'b000110, 6'b000011, 6'b000111};

        rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; ALUOp_i = '0; funct_i = '0;

        // ---- Reset state ----
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_outputs", 32'({valid_o, ALUCtrl_o, FURslt_o, hilo_we_o, mul_start_o, illegal_o}), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_ready", 32'(ready_o), 32'd1);

        // ---- Back-to-back R-type ALU stream ----
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(3'b010, stream_f[i], n);
            check("stream_cycles", 32'(n), 32'd1);
            check("stream_valid", 32'(valid_o), 32'd1);
            check("stream_code", 32'(ALUCtrl_o), 32'(stream_c[i]));
            check("stream_ready", 32'(ready_o), 32'd1);
        end
        drain();

        // ---- Stall on the second transfer ----
        send(3'b100, 6'h00, n);                 // addi
        send(3'b101, 6'h00, n);                 // slti
        ready_i = 1'b0;
        ALUOp_i = 3'b110;                       // beq waiting upstream
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check("stall_ready", 32'(ready_o), 32'd0);
            check("stall_hold", 32'({valid_o, ALUCtrl_o}), 32'({1'b1, 4'b0111}));
        end
        ready_i = 1'b1;
        send(3'b110, 6'h00, n);                 // beq
        send(3'b000, 6'h00, n);                 // lw
        drain();

        // ---- mult sequence then mfhi ----
        send(3'b010, F_MULT, n);
        ready_i = 1'b0;
        valid_i = 1'b0;
        check("mul_p1", 32'({mul_start_o, valid_o, ready_o}), 32'({1'b1, 1'b0, 1'b0}));
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk_i);
            #1;
            check("mul_seq", 32'({mul_start_o, ready_o, valid_o, hilo_we_o}),
                  32'({1'b0, 1'b0, (k >= MUL_LAT + 1), (k >= MUL_LAT + 1)}));
        end
        check("mul_code", 32'(ALUCtrl_o), 32'(4'b1110));
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("mul_after", 32'({valid_o, hilo_we_o, ready_o}), 32'({1'b0, 1'b0, 1'b1}));
        send(3'b010, F_MFHI, n);
        check("mfhi_fu", 32'(FURslt_o), 32'd2);
        drain();

        // ---- Shifter ops (sra/srav depend on build) ----
        for (int i = 0; i < 6; i++) send(3'b010, shift_f[i], n);
        drain();

        // ---- Illegal combinations: delivered, no stall ----
        send(3'b111, 6'h00, n);
        check("ill_op", 32'({valid_o, illegal_o, ALUCtrl_o, ready_o}), 32'({1'b1, 1'b1, 4'b1111, 1'b1}));
        send(3'b010, 6'b111111, n);
        check("ill_funct_cycles", 32'(n), 32'd1);
        check("ill_funct", 32'({valid_o, illegal_o, ALUCtrl_o, ready_o}), 32'({1'b1, 1'b1, 4'b1111, 1'b1}));
        drain();

        // ---- Reset during MUL ----
        send(3'b010, F_MULT, n);
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        sb.delete();
        check("midrst_outputs", 32'({valid_o, ALUCtrl_o, FURslt_o, hilo_we_o, mul_start_o, illegal_o}), 32'd0);
        rst_i = 1'b1;
        for (int i = 0; i < MUL_LAT + 2; i++) begin
            @(posedge clk_i);
            #1;
            check("midrst_quiet", 32'({valid_o, hilo_we_o, ready_o}), 32'({1'b0, 1'b0, 1'b1}));
        end
        send(3'b010, F_ADD, n);
        check("midrst_add", 32'({valid_o, ALUCtrl_o, FURslt_o}), 32'({1'b1, 4'b0010, 2'd0}));
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
